mcs4_pc_stack: RTL and testbench
================================

Name: mcs4_pc_stack

Overview:
- Parametrised program-counter and subroutine-return stack for MCS-4-family cores.
- Generalises the fixed 12-bit, 3-level address register to configurable address width and stack depth (4004 = 3 levels, 4040 = 7 levels).
- Adds a selectable overflow policy, sticky overflow/underflow flags and variable instruction length.
- Sits between the core's instruction decoder (supplies op/target once per instruction cycle) and the bus arbiter (reads address nibbles during A1..A3).

Parameters:
- ADDR_W, 12: PC/stack entry width in bits. Must be a multiple of 4 and >= 8.
- STACK_DEPTH, 3: number of return-address entries. Must be >= 1.
- WRAP_MODE, 1: 1 = circular overwrite, 4004-compatible; 0 = saturating with discard.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- step  in  1  commit strobe; asserted one cycle per instruction cycle (X3)
- op  in  3  0 HOLD, 1 INC, 2 JUMP, 3 JPAGE, 4 CALL, 5 RET; 6,7 behave as HOLD
- ilen  in  1  instruction length: 0 = one word (+1), 1 = two words (+2)
- target  in  ADDR_W  jump/call destination; JPAGE uses target[7:0] only
- clr_err  in  1  clears sticky flags
- nib_idx  in  clog2(ADDR_W/4)  nibble select for bus output; 0 = least significant nibble
- pc  out  ADDR_W  current program counter
- addr_nib  out  4  pc[4*nib_idx +: 4], combinational
- top  out  ADDR_W  most recently pushed entry, stack[ptr-1 mod STACK_DEPTH]
- depth  out  clog2(STACK_DEPTH+1)  valid entries, 0..STACK_DEPTH
- overflow  out  1  sticky: CALL issued while depth == STACK_DEPTH
- underflow  out  1  sticky: RET issued while depth == 0

Behaviour:
- Clock and reset: clk is the only clock. rst is synchronous and active-high; it has priority over everything else.
- Reset values: pc = 0, ptr = 0, depth = 0, overflow = 0, underflow = 0, all stack entries = 0.
- Sequencing:
  - State changes only on a clk edge with step = 1. With step = 0, all state holds and op/target/ilen are ignored.
  - Latency: one edge. The new pc is visible the cycle after step.
- Next address:
  - nxt = (pc + 1 + ilen) mod 2^ADDR_W. All address arithmetic wraps, so 0xFFF + 1 = 0x000 for ADDR_W = 12.
- Operations:
  - HOLD: no state change.
  - INC: pc <= nxt.
  - JUMP: pc <= target.
  - JPAGE: pc <= {nxt[ADDR_W-1:8], target[7:0]}. The page is taken from nxt, so a jump issued from the last word(s) of a page lands in the following page (4004 end-of-page rule).
  - CALL, depth < STACK_DEPTH: stack[ptr] <= nxt; ptr <= ptr+1 mod STACK_DEPTH; depth++; pc <= target.
  - CALL, depth == STACK_DEPTH:
    - pc <= target and overflow <= 1 in both modes.
    - WRAP_MODE=1: stack[ptr] <= nxt (overwrites oldest); ptr advances; depth stays STACK_DEPTH.
    - WRAP_MODE=0: stack, ptr and depth unchanged; the return address is discarded.
  - RET, depth > 0: pc <= stack[ptr-1 mod STACK_DEPTH]; ptr decrements mod STACK_DEPTH; depth--.
  - RET, depth == 0:
    - underflow <= 1 in both modes.
    - WRAP_MODE=1: pc <= stack[ptr-1 mod STACK_DEPTH] (stale entry); ptr decrements; depth stays 0.
    - WRAP_MODE=0: pc <= nxt; ptr unchanged.
- Flags:
  - overflow and underflow are sticky; they clear on rst, or on clr_err = 1.
  - If clr_err and a new error event occur on the same edge, set wins for that flag; the other flag clears.
  - clr_err is honoured regardless of step.
- Output timing: top and depth are registered-state views. top is undefined in meaning (but deterministic) when depth = 0.
- Reset mid-sequence: any partially nested call chain is abandoned; the next instruction fetch is from address 0.

Test Plan:
- Reset, then 3 x (step, INC, ilen=0) -> pc = 0x003; then INC ilen=1 -> pc = 0x005; depth = 0, flags = 0.
- pc=0x0FE, JPAGE target=0x34, ilen=0 -> pc = 0x034. Repeat from pc=0x0FF -> pc = 0x134. From 0xFFF, INC -> 0x000.
- DEPTH=3, WRAP=1, from pc=0x010: CALL 0x100 (ilen=1), CALL 0x200, CALL 0x300, CALL 0x400 -> depth = 3, overflow = 1, top = 0x302. Then 3 x RET -> pc = 0x302, 0x202, 0x102.
- Same sequence with WRAP=0: 4th CALL -> pc = 0x400, depth = 3, top = 0x202. Then RET x3 -> pc = 0x202, 0x102, 0x012; 4th RET -> pc = 0x013, underflow = 1.
- DEPTH=7: nest 7 CALLs -> depth = 7, overflow = 0; 8th CALL -> overflow = 1. clr_err asserted on the same edge as an underflowing RET -> underflow = 1, overflow = 0.
- step=0 with op=JUMP held for 5 cycles -> pc unchanged. rst asserted mid-nest (depth = 2) -> next cycle pc = 0, depth = 0, flags = 0. nib_idx = 0/1/2 with pc = 0xABC -> addr_nib = 0xC/0xB/0xA.

Source files
------------

// File: rtl/mcs4_pc_stack.sv
// mcs4_pc_stack
// Program counter plus circular return-address stack for MCS-4-family cores.
// The decoder commits one operation per instruction cycle via step. The bus
// arbiter reads the current address one nibble at a time through addr_nib.
// Overflow and underflow are sticky until rst or clr_err.
module mcs4_pc_stack #(
  parameter int ADDR_W       = 12,
  parameter int STACK_DEPTH  = 3,
  parameter int WRAP_MODE    = 1,
  localparam int NIB_W       = $clog2(ADDR_W / 4),
  localparam int DEP_W       = $clog2(STACK_DEPTH + 1),
  localparam int PTR_W       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic [2:0]        op,
  input  logic              ilen,
  input  logic [ADDR_W-1:0] target,
  input  logic              clr_err,
  input  logic [NIB_W-1:0]  nib_idx,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        addr_nib,
  output logic [ADDR_W-1:0] top,
  output logic [DEP_W-1:0]  depth,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_INC   = 3'd1,
    OP_JUMP  = 3'd2,
    OP_JPAGE = 3'd3,
    OP_CALL  = 3'd4,
    OP_RET   = 3'd5
  } op_e;

  // Low byte of an address is the in-page offset; the rest selects the page.
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(8'hFF);

  // Circular pointer helpers: the stack index always wraps at STACK_DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(STACK_DEPTH - 1)) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    if (p == {PTR_W{1'b0}}) begin
      ptr_dec = PTR_W'(STACK_DEPTH - 1);
    end else begin
      ptr_dec = p - PTR_W'(1);
    end
  endfunction

  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [ADDR_W-1:0] top_r, top_s;
  logic [PTR_W-1:0]  ptr_r, ptr_s;
  logic [DEP_W-1:0]  depth_r, depth_s;
  logic              ovf_r, ovf_s;
  logic              unf_r, unf_s;
  logic [ADDR_W-1:0] stack_r [STACK_DEPTH];

  logic [ADDR_W-1:0] nxt_s;
  logic [ADDR_W-1:0] jpage_s;
  logic [PTR_W-1:0]  ptr_dec_s;
  logic [PTR_W-1:0]  top_idx_s;
  logic              full_s;
  logic              empty_s;
  logic              wr_en_s;
  logic              ovf_set_s;
  logic              unf_set_s;

  // Shared address arithmetic; everything wraps modulo 2^ADDR_W.
  always_comb begin
    nxt_s     = pc_r + ADDR_W'(1) + ADDR_W'(ilen);
    jpage_s   = (nxt_s & ~PAGE_MASK) | (target & PAGE_MASK);
    ptr_dec_s = ptr_dec(ptr_r);
    full_s    = (depth_r == DEP_W'(STACK_DEPTH));
    empty_s   = (depth_r == {DEP_W{1'b0}});
  end

  // Next-state decode for pc, stack pointer, depth and the stack write.
  always_comb begin
    pc_s      = pc_r;
    ptr_s     = ptr_r;
    depth_s   = depth_r;
    wr_en_s   = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    if (step) begin
      case (op)
        OP_INC:   pc_s = nxt_s;
        OP_JUMP:  pc_s = target;
        OP_JPAGE: pc_s = jpage_s;
        OP_CALL: begin
          pc_s = target;
          if (!full_s) begin
            wr_en_s = 1'b1;
            ptr_s   = ptr_inc(ptr_r);
            depth_s = depth_r + DEP_W'(1);
          end else begin
            ovf_set_s = 1'b1;
            if (WRAP_MODE != 0) begin
              // Overwrite the oldest entry, 4004 style.
              wr_en_s = 1'b1;
              ptr_s   = ptr_inc(ptr_r);
            end else begin
              // Saturate: the return address is dropped.
              ptr_s = ptr_r;
            end
          end
        end
        OP_RET: begin
          if (!empty_s) begin
            pc_s    = stack_r[ptr_dec_s];
            ptr_s   = ptr_dec_s;
            depth_s = depth_r - DEP_W'(1);
          end else begin
            unf_set_s = 1'b1;
            if (WRAP_MODE != 0) begin
              // Pop a stale entry; depth cannot go below zero.
              pc_s  = stack_r[ptr_dec_s];
              ptr_s = ptr_dec_s;
            end else begin
              pc_s = nxt_s;
            end
          end
        end
        default: pc_s = pc_r;
      endcase
    end else begin
      pc_s = pc_r;
    end
  end

  // Sticky flags: clr_err works without step, a same-edge error wins.
  always_comb begin
    if (ovf_set_s) begin
      ovf_s = 1'b1;
    end else if (clr_err) begin
      ovf_s = 1'b0;
    end else begin
      ovf_s = ovf_r;
    end
    if (unf_set_s) begin
      unf_s = 1'b1;
    end else if (clr_err) begin
      unf_s = 1'b0;
    end else begin
      unf_s = unf_r;
    end
  end

  // Look ahead to the entry that will sit below the pointer after this edge,
  // so top can be a plain register.
  always_comb begin
    top_idx_s = ptr_dec(ptr_s);
    if (wr_en_s && (top_idx_s == ptr_r)) begin
      top_s = nxt_s;
    end else begin
      top_s = stack_r[top_idx_s];
    end
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r    <= {ADDR_W{1'b0}};
      top_r   <= {ADDR_W{1'b0}};
      ptr_r   <= {PTR_W{1'b0}};
      depth_r <= {DEP_W{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_r[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      pc_r    <= pc_s;
      top_r   <= top_s;
      ptr_r   <= ptr_s;
      depth_r <= depth_s;
      ovf_r   <= ovf_s;
      unf_r   <= unf_s;
      if (wr_en_s) begin
        stack_r[ptr_r] <= nxt_s;
      end else begin
        stack_r[ptr_r] <= stack_r[ptr_r];
      end
    end
  end

  // Bus nibble select; an index past the top nibble reads as zero.
  always_comb begin
    addr_nib = 4'h0;
    for (int i = 0; i < ADDR_W / 4; i++) begin
      addr_nib = addr_nib | (pc_r[4*i +: 4] & {4{nib_idx == NIB_W'(i)}});
    end
  end

  assign pc        = pc_r;
  assign top       = top_r;
  assign depth     = depth_r;
  assign overflow  = ovf_r;
  assign underflow = unf_r;

endmodule

// File: tb/tb_mcs4_pc_stack.sv
// Testbench for mcs4_pc_stack: three instances (3-deep wrap, 3-deep saturate,
// 7-deep wrap) driven by directed vectors; expectations go through a queue
// and a negedge monitor checks each instance the cycle after its step.
module tb_mcs4_pc_stack;

  localparam logic [2:0] HOLD = 3'd0;
  localparam logic [2:0] INC  = 3'd1;
  localparam logic [2:0] JMP  = 3'd2;
  localparam logic [2:0] JPG  = 3'd3;
  localparam logic [2:0] CALL = 3'd4;
  localparam logic [2:0] RET  = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  step_v = 3'b000;
  logic [2:0]  op = 3'd0;
  logic        ilen = 1'b0;
  logic [11:0] target = 12'h000;
  logic        clr_err = 1'b0;
  logic [1:0]  nib_idx = 2'd0;

  logic [11:0] pc_a, top_a, pc_b, top_b, pc_c, top_c;
  logic [3:0]  nib_a, nib_b, nib_c;
  logic [1:0]  depth_a, depth_b;
  logic [2:0]  depth_c;
  logic        ovf_a, unf_a, ovf_b, unf_b, ovf_c, unf_c;

  typedef struct {
    int          d;
    logic [11:0] pc;
    int          dep;
    logic [11:0] top;
    logic        ovf;
    logic        unf;
    logic        cn;
    logic [3:0]  nib;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  logic [2:0] fired = 3'b000;

  always #5 clk = ~clk;

  mcs4_pc_stack #(.ADDR_W(12), .STACK_DEPTH(3), .WRAP_MODE(1)) u_a (
    .clk(clk), .rst(rst), .step(step_v[0]), .op(op), .ilen(ilen), .target(target),
    .clr_err(clr_err), .nib_idx(nib_idx), .pc(pc_a), .addr_nib(nib_a), .top(top_a),
    .depth(depth_a), .overflow(ovf_a), .underflow(unf_a));

  mcs4_pc_stack #(.ADDR_W(12), .STACK_DEPTH(3), .WRAP_MODE(0)) u_b (
    .clk(clk), .rst(rst), .step(step_v[1]), .op(op), .ilen(ilen), .target(target),
    .clr_err(clr_err), .nib_idx(nib_idx), .pc(pc_b), .addr_nib(nib_b), .top(top_b),
    .depth(depth_b), .overflow(ovf_b), .underflow(unf_b));

  mcs4_pc_stack #(.ADDR_W(12), .STACK_DEPTH(7), .WRAP_MODE(1)) u_c (
    .clk(clk), .rst(rst), .step(step_v[2]), .op(op), .ilen(ilen), .target(target),
    .clr_err(clr_err), .nib_idx(nib_idx), .pc(pc_c), .addr_nib(nib_c), .top(top_c),
    .depth(depth_c), .overflow(ovf_c), .underflow(unf_c));

  task automatic cmp(input string nm, input int d, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d got=%h want=%h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // One step on instance d; the expected post-edge state is queued first.
  task automatic issue(input int d, input logic [2:0] o, input logic il, input logic [11:0] tg,
                       input logic [11:0] e_pc, input int e_dep, input logic [11:0] e_top,
                       input logic e_ovf, input logic e_unf, input logic cl = 1'b0,
                       input logic [1:0] ni = 2'd0, input logic e_cn = 1'b0,
                       input logic [3:0] e_nib = 4'h0);
    exp_t e;
    @(posedge clk); #1;
    op = o; ilen = il; target = tg; clr_err = cl; nib_idx = ni;
    step_v = 3'b000;
    step_v[d] = 1'b1;
    e = '{d, e_pc, e_dep, e_top, e_ovf, e_unf, e_cn, e_nib};
    sb_q.push_back(e);
    @(posedge clk); #1;
    step_v = 3'b000;
    clr_err = 1'b0;
  endtask

  // Reset all instances while a JUMP step is offered; reset must win.
  task automatic reset_all();
    exp_t e;
    @(posedge clk); #1;
    rst = 1'b1; step_v = 3'b111; op = JMP; target = 12'hFFF; ilen = 1'b1;
    for (int d = 0; d < 3; d++) begin
      e = '{d, 12'h000, 0, 12'h000, 1'b0, 1'b0, 1'b0, 4'h0};
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    rst = 1'b0; step_v = 3'b000;
  endtask

  always @(posedge clk) fired <= step_v;

  // Monitor: every instance stepped on the last edge pops one expectation.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [11:0] a_pc, a_top;
    int          a_dep;
    logic        a_ovf, a_unf;
    logic [3:0]  a_nib;
    for (int d = 0; d < 3; d++) begin
      if (fired[d]) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty dut=%0d got=output want=expectation", d);
        end else begin
          e = sb_q.pop_front();
          case (d)
            0: begin a_pc = pc_a; a_top = top_a; a_dep = int'(depth_a); a_ovf = ovf_a; a_unf = unf_a; a_nib = nib_a; end
            1: begin a_pc = pc_b; a_top = top_b; a_dep = int'(depth_b); a_ovf = ovf_b; a_unf = unf_b; a_nib = nib_b; end
            default: begin a_pc = pc_c; a_top = top_c; a_dep = int'(depth_c); a_ovf = ovf_c; a_unf = unf_c; a_nib = nib_c; end
          endcase
          cmp("pc", d, a_pc, e.pc);
          cmp("depth", d, 12'(a_dep), 12'(e.dep));
          cmp("top", d, a_top, e.top);
          cmp("overflow", d, 12'(a_ovf), 12'(e.ovf));
          cmp("underflow", d, 12'(a_unf), 12'(e.unf));
          if (e.cn) cmp("addr_nib", d, 12'(a_nib), 12'(e.nib));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    reset_all();

    // Instance a: increment, page jumps, wrap, nibble readout.
    issue(0, INC, 1'b0, 12'h000, 12'h001, 0, 12'h000, 1'b0, 1'b0);
    issue(0, INC, 1'b0, 12'h000, 12'h002, 0, 12'h000, 1'b0, 1'b0);
    issue(0, INC, 1'b0, 12'h000, 12'h003, 0, 12'h000, 1'b0, 1'b0);
    issue(0, INC, 1'b1, 12'h000, 12'h005, 0, 12'h000, 1'b0, 1'b0);
    issue(0, JMP, 1'b0, 12'h0FE, 12'h0FE, 0, 12'h000, 1'b0, 1'b0);
    issue(0, JPG, 1'b0, 12'h934, 12'h034, 0, 12'h000, 1'b0, 1'b0);
    issue(0, JMP, 1'b0, 12'h0FF, 12'h0FF, 0, 12'h000, 1'b0, 1'b0);
    issue(0, JPG, 1'b0, 12'h034, 12'h134, 0, 12'h000, 1'b0, 1'b0);
    issue(0, JMP, 1'b0, 12'hFFF, 12'hFFF, 0, 12'h000, 1'b0, 1'b0);
    issue(0, INC, 1'b0, 12'h000, 12'h000, 0, 12'h000, 1'b0, 1'b0);
    issue(0, JMP, 1'b0, 12'hABC, 12'hABC, 0, 12'h000, 1'b0, 1'b0);
    issue(0, HOLD, 1'b1, 12'h123, 12'hABC, 0, 12'h000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'hC);
    issue(0, HOLD, 1'b0, 12'h456, 12'hABC, 0, 12'h000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 4'hB);
    issue(0, 3'd6, 1'b1, 12'h777, 12'hABC, 0, 12'h000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'hA);
    issue(0, 3'd7, 1'b0, 12'h777, 12'hABC, 0, 12'h000, 1'b0, 1'b0);

    // Instance a: nest past full with wrap, then unwind and underflow.
    issue(0, JMP,  1'b0, 12'h010, 12'h010, 0, 12'h000, 1'b0, 1'b0);
    issue(0, CALL, 1'b1, 12'h100, 12'h100, 1, 12'h012, 1'b0, 1'b0);
    issue(0, CALL, 1'b1, 12'h200, 12'h200, 2, 12'h102, 1'b0, 1'b0);
    issue(0, CALL, 1'b1, 12'h300, 12'h300, 3, 12'h202, 1'b0, 1'b0);
    issue(0, CALL, 1'b1, 12'h400, 12'h400, 3, 12'h302, 1'b1, 1'b0);
    issue(0, RET,  1'b0, 12'h000, 12'h302, 2, 12'h202, 1'b1, 1'b0);
    issue(0, RET,  1'b0, 12'h000, 12'h202, 1, 12'h102, 1'b1, 1'b0);
    issue(0, RET,  1'b0, 12'h000, 12'h102, 0, 12'h302, 1'b1, 1'b0);
    issue(0, RET,  1'b0, 12'h000, 12'h302, 0, 12'h202, 1'b1, 1'b1);
    issue(0, JMP,  1'b0, 12'h050, 12'h050, 0, 12'h202, 1'b1, 1'b1);
    issue(0, CALL, 1'b0, 12'h060, 12'h060, 1, 12'h051, 1'b1, 1'b1);
    issue(0, CALL, 1'b0, 12'h070, 12'h070, 2, 12'h061, 1'b1, 1'b1);

    // Inputs without step are ignored.
    @(posedge clk); #1;
    op = JMP; target = 12'hFFF; ilen = 1'b1; step_v = 3'b000;
    repeat (5) @(posedge clk);
    issue(0, HOLD, 1'b0, 12'h000, 12'h070, 2, 12'h061, 1'b1, 1'b1);

    // Instance b: saturating stack discards the fourth return address.
    issue(1, JMP,  1'b0, 12'h010, 12'h010, 0, 12'h000, 1'b0, 1'b0);
    issue(1, CALL, 1'b1, 12'h100, 12'h100, 1, 12'h012, 1'b0, 1'b0);
    issue(1, CALL, 1'b1, 12'h200, 12'h200, 2, 12'h102, 1'b0, 1'b0);
    issue(1, CALL, 1'b1, 12'h300, 12'h300, 3, 12'h202, 1'b0, 1'b0);
    issue(1, CALL, 1'b1, 12'h400, 12'h400, 3, 12'h202, 1'b1, 1'b0);
    issue(1, RET,  1'b0, 12'h000, 12'h202, 2, 12'h102, 1'b1, 1'b0);
    issue(1, RET,  1'b0, 12'h000, 12'h102, 1, 12'h012, 1'b1, 1'b0);
    issue(1, RET,  1'b0, 12'h000, 12'h012, 0, 12'h202, 1'b1, 1'b0);
    issue(1, RET,  1'b0, 12'h000, 12'h013, 0, 12'h202, 1'b1, 1'b1);

    // Reset while instance a is two calls deep.
    reset_all();

    // Instance c: seven-deep nest, overflow, unwind, clear/set collision.
    for (int k = 1; k <= 7; k++) begin
      issue(2, CALL, 1'b0, 12'(k * 16), 12'(k * 16), k, 12'((k - 1) * 16 + 1), 1'b0, 1'b0);
    end
    issue(2, CALL, 1'b0, 12'h080, 12'h080, 7, 12'h071, 1'b1, 1'b0);
    for (int j = 1; j <= 7; j++) begin
      issue(2, RET, 1'b0, 12'h000, 12'((8 - j) * 16 + 1), 7 - j,
            (j == 7) ? 12'h071 : 12'((7 - j) * 16 + 1), 1'b1, 1'b0);
    end
    issue(2, RET,  1'b0, 12'h000, 12'h071, 0, 12'h061, 1'b0, 1'b1, 1'b1);
    issue(2, HOLD, 1'b0, 12'h000, 12'h071, 0, 12'h061, 1'b0, 1'b0, 1'b1);

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d want=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
